// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants, FSM state type and round-constant table.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NUM_ROUNDS   = 10;
    localparam int KEY_BITS     = 128;
    localparam int EXP_KEY_BITS = 1408;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // RCON[1..10]; any other round index yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] value;
        value = 8'h00;
        case (rnd)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1b;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : 8-bit combinational AES forward S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Entry for input 0x00 sits in the most significant byte.
    localparam logic [2047:0] C_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0]  w_rev_idx;
    logic [10:0] w_bit_base;

    assign w_rev_idx  = 8'hff - value;
    assign w_bit_base = {w_rev_idx, 3'b000};
    assign subst      = C_SBOX_TABLE[w_bit_base +: 8];

endmodule
`default_nettype wire

// File: rtl/key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : key_expansion
// Description : Iterative AES-128 key schedule, one round key per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module key_expansion
    import aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [KEY_BITS-1:0]     key_in,
    input  logic                    key_valid,
    output logic                    key_ready,
    output logic [EXP_KEY_BITS-1:0] expanded_key,
    output logic                    expanded_valid
);

    state_t                r_state;
    logic [3:0]            r_rnd;
    logic [KEY_BITS-1:0]   r_slots [0:NUM_ROUNDS];
    logic                  r_key_ready;
    logic                  r_expanded_valid;

    logic [KEY_BITS-1:0]   w_prev_slot;
    logic [KEY_BITS-1:0]   w_next_slot;
    logic [31:0]           w_rot_word;
    logic [31:0]           w_sub_word;
    logic [31:0]           w_temp;
    logic [31:0]           w_w0;
    logic [31:0]           w_w1;
    logic [31:0]           w_w2;
    logic [31:0]           w_w3;

    // Previous slot (rnd-1) feeds the single shared round-step datapath.
    always_comb begin
        w_prev_slot = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (r_rnd == 4'(i + 1)) begin
                w_prev_slot = r_slots[i];
            end
        end
    end

    assign w_rot_word = {w_prev_slot[23:0], w_prev_slot[31:24]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .value (w_rot_word[8*g +: 8]),
                .subst (w_sub_word[8*g +: 8])
            );
        end
    endgenerate

    assign w_temp      = w_sub_word ^ {rcon(r_rnd), 24'h000000};
    assign w_w0        = w_prev_slot[127:96] ^ w_temp;
    assign w_w1        = w_prev_slot[95:64]  ^ w_w0;
    assign w_w2        = w_prev_slot[63:32]  ^ w_w1;
    assign w_w3        = w_prev_slot[31:0]   ^ w_w2;
    assign w_next_slot = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_rnd            <= 4'd0;
            r_key_ready      <= 1'b1;
            r_expanded_valid <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_EXPAND: begin
                    for (int i = 1; i <= NUM_ROUNDS; i++) begin
                        if (r_rnd == 4'(i)) begin
                            r_slots[i] <= w_next_slot;
                        end
                    end
                    if (r_rnd == 4'(NUM_ROUNDS)) begin
                        r_state          <= ST_DONE;
                        r_key_ready      <= 1'b1;
                        r_expanded_valid <= 1'b1;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new key; DONE restarts back-to-back.
                    if (key_valid) begin
                        r_state          <= ST_EXPAND;
                        r_rnd            <= 4'd1;
                        r_key_ready      <= 1'b0;
                        r_expanded_valid <= 1'b0;
                        r_slots[0]       <= key_in;
                        for (int i = 1; i <= NUM_ROUNDS; i++) begin
                            r_slots[i] <= '0;
                        end
                    end
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g <= NUM_ROUNDS; g++) begin : g_slot
            assign expanded_key[KEY_BITS*g +: KEY_BITS] = r_slots[g];
        end
    endgenerate

    assign key_ready      = r_key_ready;
    assign expanded_valid = r_expanded_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_expansion
// Description : Directed self-checking bench for key_expansion (FIPS-197 vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_expansion;

    localparam logic [127:0] C_KEY_FIPS    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_FIPS_SLOT1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] C_FIPS_SLOT10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_KEY_ZERO    = 128'h0;
    localparam logic [127:0] C_ZERO_SLOT1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] C_ZERO_SLOT10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic           clk;
    logic           reset;
    logic [127:0]   key_in;
    logic           key_valid;
    logic           key_ready;
    logic [1407:0]  expanded_key;
    logic           expanded_valid;

    int errors;
    int checks;

    key_expansion dut (
        .clk            (clk),
        .reset          (reset),
        .key_in         (key_in),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .expanded_key   (expanded_key),
        .expanded_valid (expanded_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [127:0] slot0  = expanded_key[127:0];
    wire [127:0] slot1  = expanded_key[255:128];
    wire [127:0] slot10 = expanded_key[1407:1280];

    // Presents one key for one cycle; the accepting edge has passed on return.
    task automatic start_key(input logic [127:0] key);
        @(negedge clk);
        key_in    = key;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Edges until expanded_valid rises (99 on timeout); flags key_ready seen high meanwhile.
    task automatic wait_valid(output int cycles, output logic ready_high);
        cycles     = 99;
        ready_high = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (expanded_valid === 1'b1) begin
                cycles = i;
                return;
            end
            if (key_ready !== 1'b0) ready_high = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (expanded_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid actual=%b required=0", expanded_valid);
        end
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready actual=%b required=1", key_ready);
        end
        checks++;
        if (expanded_key !== '0) begin
            errors++;
            $display("FAIL reset_key actual_ones=%0d required_ones=0", $countones(expanded_key));
        end
    endtask

    task automatic test_fips_vector();
        int     cyc;
        logic   rdy;
        logic [127:0] held;
        start_key(C_KEY_FIPS);
        checks++;
        if (key_ready !== 1'b0 || expanded_valid !== 1'b0) begin
            errors++;
            $display("FAIL fips_accept ready=%b valid=%b required ready=0 valid=0", key_ready, expanded_valid);
        end
        wait_valid(cyc, rdy);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL fips_latency actual=%0d required=10", cyc);
        end
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL fips_ready_in_expand actual=1 required=0");
        end
        checks++;
        if (slot0 !== C_KEY_FIPS) begin
            errors++;
            $display("FAIL fips_slot0 actual=%h required=%h", slot0, C_KEY_FIPS);
        end
        checks++;
        if (slot1 !== C_FIPS_SLOT1) begin
            errors++;
            $display("FAIL fips_slot1 actual=%h required=%h", slot1, C_FIPS_SLOT1);
        end
        checks++;
        if (slot10 !== C_FIPS_SLOT10) begin
            errors++;
            $display("FAIL fips_slot10 actual=%h required=%h", slot10, C_FIPS_SLOT10);
        end
        held = slot10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (expanded_valid !== 1'b1 || key_ready !== 1'b1 || slot10 !== C_FIPS_SLOT10) begin
            errors++;
            $display("FAIL fips_done_hold valid=%b ready=%b slot10=%h required 1 1 %h",
                     expanded_valid, key_ready, slot10, held);
        end
    endtask

    task automatic test_zero_key();
        int   cyc;
        logic rdy;
        start_key(C_KEY_ZERO);
        wait_valid(cyc, rdy);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL zero_latency actual=%0d required=10", cyc);
        end
        checks++;
        if (slot1 !== C_ZERO_SLOT1) begin
            errors++;
            $display("FAIL zero_slot1 actual=%h required=%h", slot1, C_ZERO_SLOT1);
        end
        checks++;
        if (slot10 !== C_ZERO_SLOT10) begin
            errors++;
            $display("FAIL zero_slot10 actual=%h required=%h", slot10, C_ZERO_SLOT10);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic rdy;
        start_key(C_KEY_ZERO);
        wait_valid(cyc, rdy);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL b2b_first_latency actual=%0d required=10", cyc);
        end
        // Present the second key in the very first DONE cycle.
        start_key(C_KEY_FIPS);
        checks++;
        if (expanded_valid !== 1'b0 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept valid=%b ready=%b required valid=0 ready=0", expanded_valid, key_ready);
        end
        wait_valid(cyc, rdy);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL b2b_second_latency actual=%0d required=10", cyc);
        end
        checks++;
        if (slot1 !== C_FIPS_SLOT1) begin
            errors++;
            $display("FAIL b2b_slot1 actual=%h required=%h", slot1, C_FIPS_SLOT1);
        end
        checks++;
        if (slot10 !== C_FIPS_SLOT10) begin
            errors++;
            $display("FAIL b2b_slot10 actual=%h required=%h", slot10, C_FIPS_SLOT10);
        end
    endtask

    task automatic test_ignore_during_expand();
        int   cyc;
        logic rdy;
        start_key(C_KEY_ZERO);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (key_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignore_ready_rnd4 actual=%b required=0", key_ready);
        end
        start_key(C_KEY_FIPS);
        wait_valid(cyc, rdy);
        checks++;
        if (cyc !== 6 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_remaining actual_cycles=%0d ready_high=%b required 6 0", cyc, rdy);
        end
        checks++;
        if (slot0 !== C_KEY_ZERO || slot1 !== C_ZERO_SLOT1) begin
            errors++;
            $display("FAIL ignore_slot1 actual=%h required=%h", slot1, C_ZERO_SLOT1);
        end
        checks++;
        if (slot10 !== C_ZERO_SLOT10) begin
            errors++;
            $display("FAIL ignore_slot10 actual=%h required=%h", slot10, C_ZERO_SLOT10);
        end
    endtask

    task automatic test_reset_mid_expand();
        int   cyc;
        logic rdy;
        start_key(C_KEY_FIPS);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (expanded_key !== '0) begin
            errors++;
            $display("FAIL midreset_key actual_ones=%0d required_ones=0", $countones(expanded_key));
        end
        checks++;
        if (expanded_valid !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_flags valid=%b ready=%b required valid=0 ready=1", expanded_valid, key_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (expanded_key !== '0 || expanded_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle_hold valid=%b ones=%0d required 0 0", expanded_valid, $countones(expanded_key));
        end
        start_key(C_KEY_ZERO);
        wait_valid(cyc, rdy);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL midreset_latency actual=%0d required=10", cyc);
        end
        checks++;
        if (slot1 !== C_ZERO_SLOT1) begin
            errors++;
            $display("FAIL midreset_slot1 actual=%h required=%h", slot1, C_ZERO_SLOT1);
        end
        checks++;
        if (slot10 !== C_ZERO_SLOT10) begin
            errors++;
            $display("FAIL midreset_slot10 actual=%h required=%h", slot10, C_ZERO_SLOT10);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fips_vector();
        test_zero_key();
        test_back_to_back();
        test_ignore_during_expand();
        test_reset_mid_expand();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
